// File: rtl/conv_out_writeback.sv
// conv_out_writeback: accumulates one output pixel's products between
// accum_sload pulses, then adds bias, rescales, optionally clamps negatives
// (CONV_RELU_EN), saturates, and writes the word to sequential addresses.
// Define CONV_RELU_EN to compile in the ReLU stage.
module conv_out_writeback #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int ACC_WIDTH      = 40,
  parameter int OUT_ADDR_WIDTH = 10,
  parameter int OUT_ADDR_BASE  = 0,
  parameter int NUM_OUT_PIXELS = 100
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      product_valid,
  input  logic                      accum_sload,
  input  logic [2*DATA_WIDTH-1:0]   product,
  input  logic [DATA_WIDTH-1:0]     bias,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic                      out_wren,
  output logic [OUT_ADDR_WIDTH-1:0] pixel_count,
  output logic                      out_done
);

  localparam int CNT_W = $clog2(NUM_OUT_PIXELS + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -(ACC_WIDTH'(1) <<< (DATA_WIDTH - 1));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]              emit_cnt_q, emit_cnt_d;
  logic                          s1_vld_q, s1_vld_d;
  logic signed [ACC_WIDTH-1:0]   s1_sum_q, s1_sum_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic                          out_wren_q, out_wren_d;
  logic [OUT_ADDR_WIDTH-1:0]     pixel_count_q, pixel_count_d;
  logic                          out_done_q, out_done_d;

  logic                          qual;
  logic signed [ACC_WIDTH-1:0]   prod_ext, bias_ext, scaled, clipped;

  assign qual     = enable & product_valid;
  assign prod_ext = ACC_WIDTH'($signed(product));
  assign bias_ext = ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;

  // State register plus all datapath flops; reset discards any in-flight emit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      emit_cnt_q    <= '0;
      s1_vld_q      <= 1'b0;
      s1_sum_q      <= '0;
      out_data_q    <= '0;
      out_wren_q    <= 1'b0;
      pixel_count_q <= '0;
      out_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      emit_cnt_q    <= emit_cnt_d;
      s1_vld_q      <= s1_vld_d;
      s1_sum_q      <= s1_sum_d;
      out_data_q    <= out_data_d;
      out_wren_q    <= out_wren_d;
      pixel_count_q <= pixel_count_d;
      out_done_q    <= out_done_d;
    end
  end

  // Next state: first sload opens a pixel, last emission closes the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (qual && accum_sload) state_d = S_ACCUM;
      S_ACCUM: if (qual && accum_sload && emit_cnt_q == CNT_W'(NUM_OUT_PIXELS - 1)) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // FSM outputs: accumulate, and on sload hand the finished sum to stage 1
  always_comb begin
    acc_d      = acc_q;
    emit_cnt_d = emit_cnt_q;
    s1_vld_d   = 1'b0;
    s1_sum_d   = s1_sum_q;
    case (state_q)
      S_IDLE: if (qual && accum_sload) acc_d = prod_ext;
      S_ACCUM: begin
        if (qual) begin
          if (accum_sload) begin
            s1_vld_d   = 1'b1;
            s1_sum_d   = acc_q + bias_ext;
            acc_d      = prod_ext;
            emit_cnt_d = emit_cnt_q + CNT_W'(1);
          end else begin
            acc_d = acc_q + prod_ext;
          end
        end
      end
      default: ;
    endcase
  end

  // Stage 2: rescale (floor), optional ReLU, saturate; drains regardless of enable
  always_comb begin
    scaled = s1_sum_q >>> FRAC_BITS;
`ifdef CONV_RELU_EN
    if (scaled < 0) scaled = '0;
`else
`endif
    if (scaled > SAT_MAX)      clipped = SAT_MAX;
    else if (scaled < SAT_MIN) clipped = SAT_MIN;
    else                       clipped = scaled;
    out_data_d    = s1_vld_q ? clipped[DATA_WIDTH-1:0] : out_data_q;
    out_wren_d    = s1_vld_q;
    pixel_count_d = pixel_count_q + OUT_ADDR_WIDTH'(out_wren_q);
    out_done_d    = out_done_q |
                    (out_wren_q && pixel_count_q == OUT_ADDR_WIDTH'(NUM_OUT_PIXELS - 1));
  end

  assign out_data    = out_data_q;
  assign out_wren    = out_wren_q;
  assign out_addr    = OUT_ADDR_WIDTH'(OUT_ADDR_BASE) + pixel_count_q;
  assign pixel_count = pixel_count_q;
  assign out_done    = out_done_q;

endmodule
